// File: rtl/grid_lsq_responder.sv
// Load/store responder for grid PR slots: round-robin arbiter, in-order request queue,
// single memory port and in-order load return. Optional macro: RCA_LSQ_LOAD_EXTRACT_EN.
module grid_lsq_responder #(
    parameter int NUM_SLOTS   = 4,
    parameter int QUEUE_DEPTH = 4,
    parameter int XLEN        = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_SLOTS-1:0][XLEN-1:0]  slot_addr,
    input  logic [NUM_SLOTS-1:0][XLEN-1:0]  slot_data,
    input  logic [NUM_SLOTS-1:0][2:0]       slot_fn3,
    input  logic [NUM_SLOTS-1:0]            slot_load,
    input  logic [NUM_SLOTS-1:0]            slot_store,
    input  logic [NUM_SLOTS-1:0]            slot_new_request,
    output logic [NUM_SLOTS-1:0]            slot_lsq_full,
    output logic [NUM_SLOTS-1:0][XLEN-1:0]  slot_load_data,
    output logic [NUM_SLOTS-1:0]            slot_load_complete,
    output logic [XLEN-1:0]                 mem_addr,
    output logic [XLEN-1:0]                 mem_wdata,
    output logic [2:0]                      mem_fn3,
    output logic                            mem_load,
    output logic                            mem_store,
    output logic                            mem_request,
    input  logic                            mem_ack,
    input  logic [XLEN-1:0]                 mem_rdata,
    input  logic                            mem_rvalid,
    output logic                            protocol_error
);

    localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
        logic [2:0]      fn3;
        logic            load;
        logic            store;
        logic [SW-1:0]   slot_id;
    } req_t;

`ifdef RCA_LSQ_LOAD_EXTRACT_EN
    typedef struct packed {
        logic [SW-1:0] slot_id;
        logic [1:0]    addr_lo;
        logic [2:0]    fn3;
    } trk_t;

    function automatic logic [XLEN-1:0] extract_load(input logic [XLEN-1:0] raw,
                                                     input logic [1:0]      lo,
                                                     input logic [2:0]      fn3);
        logic [XLEN-1:0] sh;
        sh = raw >> {lo, 3'b000};
        case (fn3)
            3'b000:  return {{(XLEN-8){sh[7]}}, sh[7:0]};
            3'b100:  return {{(XLEN-8){1'b0}}, sh[7:0]};
            3'b001:  return {{(XLEN-16){sh[15]}}, sh[15:0]};
            3'b101:  return {{(XLEN-16){1'b0}}, sh[15:0]};
            default: return raw;
        endcase
    endfunction
`else
    typedef struct packed {
        logic [SW-1:0] slot_id;
    } trk_t;
`endif

    // Request queue and pending-load tracker state
    req_t                 q_mem_q [QUEUE_DEPTH];
    logic [PW-1:0]        q_wr_q, q_wr_d, q_rd_q, q_rd_d;
    logic [CW-1:0]        q_count_q, q_count_d;
    trk_t                 t_mem_q [QUEUE_DEPTH];
    logic [PW-1:0]        t_wr_q, t_wr_d, t_rd_q, t_rd_d;
    logic [CW-1:0]        t_count_q, t_count_d;
    logic [SW-1:0]        rr_ptr_q, rr_ptr_d;
    logic                 protocol_error_q, protocol_error_d;
    logic [NUM_SLOTS-1:0] slot_load_complete_q, slot_load_complete_d;
    logic [NUM_SLOTS-1:0][XLEN-1:0] slot_load_data_q, slot_load_data_d;

    logic [NUM_SLOTS-1:0] grant;
    logic [SW-1:0]        grant_id;
    logic                 grant_valid;
    logic                 queue_full, queue_empty, trk_full, trk_empty;
    logic                 push, pop, trk_push, trk_pop;
    req_t                 push_entry, head;
    trk_t                 trk_entry, trk_head;
    logic [XLEN-1:0]      ret_data;

    // Round-robin scan starting at rr_ptr; the first requesting slot wins.
    always_comb begin
        int idx;
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        grant       = '0;
        grant_id    = '0;
        grant_valid = 1'b0;
        idx         = 0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_SLOTS) idx = idx - NUM_SLOTS;
            if (!grant_valid && slot_new_request[idx[SW-1:0]]) begin
                grant_valid = 1'b1;
                grant_id    = idx[SW-1:0];
            end
        end
        if (grant_valid) grant[grant_id] = 1'b1;
    end

    assign queue_full  = (q_count_q == CW'(QUEUE_DEPTH));
    assign queue_empty = (q_count_q == '0);
    assign trk_full    = (t_count_q == CW'(QUEUE_DEPTH));
    assign trk_empty   = (t_count_q == '0);

    assign slot_lsq_full = rst ? ({NUM_SLOTS{queue_full}} | ~grant) : '1;

    assign push = grant_valid && !queue_full;
    assign head = q_mem_q[q_rd_q];

    always_comb begin
        push_entry         = '0;
        push_entry.addr    = slot_addr[grant_id];
        push_entry.data    = slot_data[grant_id];
        push_entry.fn3     = slot_fn3[grant_id];
        push_entry.load    = slot_load[grant_id];
        push_entry.store   = slot_store[grant_id];
        push_entry.slot_id = grant_id;
    end

    // A load may only leave the queue when the tracker has room for its return slot.
    assign mem_request = !queue_empty && !(head.load && trk_full);
    assign pop         = mem_request && mem_ack;

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_fn3   = '0;
        mem_load  = 1'b0;
        mem_store = 1'b0;
        if (!queue_empty) begin
            mem_addr  = head.addr;
            mem_wdata = head.data;
            mem_fn3   = head.fn3;
            mem_load  = head.load;
            mem_store = head.store;
        end
    end

    assign trk_push = pop && head.load;
    assign trk_pop  = mem_rvalid && !trk_empty;
    assign trk_head = t_mem_q[t_rd_q];

    always_comb begin
        trk_entry         = '0;
        trk_entry.slot_id = head.slot_id;
`ifdef RCA_LSQ_LOAD_EXTRACT_EN
        trk_entry.addr_lo = head.addr[1:0];
        trk_entry.fn3     = head.fn3;
        ret_data          = extract_load(mem_rdata, trk_head.addr_lo, trk_head.fn3);
`else
        ret_data          = mem_rdata;
`endif
    end

    always_comb begin
        q_wr_d    = q_wr_q;
        q_rd_d    = q_rd_q;
        q_count_d = q_count_q;
        rr_ptr_d  = rr_ptr_q;
        if (push) begin
            q_wr_d   = q_wr_q + PW'(1);
            rr_ptr_d = (int'(grant_id) == NUM_SLOTS - 1) ? '0 : grant_id + SW'(1);
        end
        if (pop) q_rd_d = q_rd_q + PW'(1);
        case ({push, pop})
            2'b10:   q_count_d = q_count_q + CW'(1);
            2'b01:   q_count_d = q_count_q - CW'(1);
            default: q_count_d = q_count_q;
        endcase
    end

    always_comb begin
        t_wr_d    = t_wr_q;
        t_rd_d    = t_rd_q;
        t_count_d = t_count_q;
        if (trk_push) t_wr_d = t_wr_q + PW'(1);
        if (trk_pop)  t_rd_d = t_rd_q + PW'(1);
        case ({trk_push, trk_pop})
            2'b10:   t_count_d = t_count_q + CW'(1);
            2'b01:   t_count_d = t_count_q - CW'(1);
            default: t_count_d = t_count_q;
        endcase
    end

    // Return path: pulse the owner's completion and update only its data word.
    always_comb begin
        slot_load_complete_d = '0;
        slot_load_data_d     = slot_load_data_q;
        protocol_error_d     = protocol_error_q | (mem_rvalid && trk_empty);
        if (trk_pop) begin
            slot_load_complete_d[trk_head.slot_id] = 1'b1;
            slot_load_data_d[trk_head.slot_id]     = ret_data;
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_wr_q               <= '0;
            q_rd_q               <= '0;
            q_count_q            <= '0;
            t_wr_q               <= '0;
            t_rd_q               <= '0;
            t_count_q            <= '0;
            rr_ptr_q             <= '0;
            protocol_error_q     <= 1'b0;
            slot_load_complete_q <= '0;
            slot_load_data_q     <= '0;
        end else begin
            q_wr_q               <= q_wr_d;
            q_rd_q               <= q_rd_d;
            q_count_q            <= q_count_d;
            t_wr_q               <= t_wr_d;
            t_rd_q               <= t_rd_d;
            t_count_q            <= t_count_d;
            rr_ptr_q             <= rr_ptr_d;
            protocol_error_q     <= protocol_error_d;
            slot_load_complete_q <= slot_load_complete_d;
            slot_load_data_q     <= slot_load_data_d;
        end
    end

    // NOTE: storage arrays are not reset; the counts gate every read, so stale contents are never seen.
    always_ff @(posedge clk) begin
        if (push)     q_mem_q[q_wr_q] <= push_entry;
        if (trk_push) t_mem_q[t_wr_q] <= trk_entry;
    end

    assign slot_load_complete = slot_load_complete_q;
    assign slot_load_data     = slot_load_data_q;
    assign protocol_error     = protocol_error_q;

endmodule

// File: tb/tb_grid_lsq_responder.sv
// Self-checking bench for grid_lsq_responder: table vectors, directed corner sequences
// and a randomized run against a queue-based reference model.
module tb_grid_lsq_responder;

    localparam int N = 4;
    localparam int D = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [N-1:0][31:0]   slot_addr, slot_data;
    logic [N-1:0][2:0]    slot_fn3;
    logic [N-1:0]         slot_load, slot_store, slot_new_request;
    logic [N-1:0]         slot_lsq_full;
    logic [N-1:0][31:0]   slot_load_data;
    logic [N-1:0]         slot_load_complete;
    logic [31:0]          mem_addr, mem_wdata, mem_rdata;
    logic [2:0]           mem_fn3;
    logic                 mem_load, mem_store, mem_request, mem_ack, mem_rvalid;
    logic                 protocol_error;

    always #5 clk = ~clk;

    grid_lsq_responder #(.NUM_SLOTS(N), .QUEUE_DEPTH(D), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .slot_addr(slot_addr), .slot_data(slot_data), .slot_fn3(slot_fn3),
        .slot_load(slot_load), .slot_store(slot_store), .slot_new_request(slot_new_request),
        .slot_lsq_full(slot_lsq_full), .slot_load_data(slot_load_data),
        .slot_load_complete(slot_load_complete),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_fn3(mem_fn3),
        .mem_load(mem_load), .mem_store(mem_store), .mem_request(mem_request),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .protocol_error(protocol_error)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic drive_idle();
        slot_addr = '0; slot_data = '0; slot_fn3 = '0;
        slot_load = '0; slot_store = '0; slot_new_request = '0;
        mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_full"}, slot_lsq_full, 4'hF);
        check({tag, "_mreq"}, {mem_request, mem_load, mem_store}, 3'b000);
        check({tag, "_maddr"}, {mem_addr, mem_wdata, mem_fn3}, '0);
        check({tag, "_cmpl"}, slot_load_complete, 4'h0);
        check({tag, "_data"}, slot_load_data, '0);
        check({tag, "_err"}, protocol_error, 1'b0);
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b0;
        sample();
        check_reset_outputs("rst");
        advance();
        rst = 1'b1;
    endtask

    task automatic put_req(input int s, input bit is_load, input logic [31:0] a,
                           input logic [31:0] d, input logic [2:0] f);
        slot_new_request[s] = 1'b1;
        slot_load[s]        = is_load;
        slot_store[s]       = !is_load;
        slot_addr[s]        = a;
        slot_data[s]        = d;
        slot_fn3[s]         = f;
    endtask

    // Reference model: requests and pending loads held as plain queues.
    typedef struct { int slot; logic [31:0] addr; logic [31:0] data; logic [2:0] fn3; bit load; } mreq_t;
    typedef struct { int slot; int lo; logic [2:0] fn3; } mtrk_t;
    mreq_t            mq[$];
    mtrk_t            mt[$];
    int               m_rr;
    bit               m_err;
    logic [N-1:0]     m_cmpl;
    logic [N-1:0][31:0] m_data;

    function automatic logic [31:0] m_ext(input logic [31:0] raw, input int lo, input logic [2:0] fn3);
`ifdef RCA_LSQ_LOAD_EXTRACT_EN
        logic [31:0] sh;
        sh = raw >> (8 * lo);
        case (fn3)
            3'd0:    return (sh & 32'hFF) | (((sh & 32'h80) != 0) ? 32'hFFFFFF00 : 32'h0);
            3'd4:    return sh & 32'hFF;
            3'd1:    return (sh & 32'hFFFF) | (((sh & 32'h8000) != 0) ? 32'hFFFF0000 : 32'h0);
            3'd5:    return sh & 32'hFFFF;
            default: return raw;
        endcase
`else
        if (lo > 3 || fn3 > 3'd7) return 32'h0;
        return raw;
`endif
    endfunction

    function automatic int m_grant();
        int g;
        g = -1;
        for (int k = 0; k < N; k++)
            if (g < 0 && slot_new_request[(m_rr + k) % N]) g = (m_rr + k) % N;
        return g;
    endfunction

    task automatic model_reset();
        mq.delete(); mt.delete();
        m_rr = 0; m_err = 1'b0; m_cmpl = '0; m_data = '0;
    endtask

    task automatic model_compare();
        int  g;
        logic [N-1:0] exp_full;
        bit  exp_mreq;
        g        = m_grant();
        exp_full = (mq.size() == D) ? 4'hF : ~((g >= 0) ? (4'b0001 << g) : 4'b0000);
        exp_mreq = (mq.size() > 0) && !(mq[0].load && mt.size() == D);
        check("rnd_full", slot_lsq_full, exp_full);
        check("rnd_mreq", mem_request, exp_mreq);
        if (mq.size() > 0) begin
            check("rnd_head", {mem_addr, mem_wdata, mem_fn3, mem_load, mem_store},
                  {mq[0].addr, mq[0].data, mq[0].fn3, mq[0].load, !mq[0].load});
        end else begin
            check("rnd_idle", {mem_addr, mem_load, mem_store}, '0);
        end
        check("rnd_cmpl", slot_load_complete, m_cmpl);
        check("rnd_data", slot_load_data, m_data);
        check("rnd_err", protocol_error, m_err);
    endtask

    task automatic model_update();
        int    g;
        bit    do_push, do_pop;
        mreq_t r, h;
        mtrk_t t;
        g       = m_grant();
        do_push = (g >= 0) && (mq.size() < D);
        do_pop  = (mq.size() > 0) && !(mq[0].load && mt.size() == D) && mem_ack;
        m_cmpl  = '0;
        if (mem_rvalid) begin
            if (mt.size() == 0) m_err = 1'b1;
            else begin
                t = mt.pop_front();
                m_cmpl[t.slot] = 1'b1;
                m_data[t.slot] = m_ext(mem_rdata, t.lo, t.fn3);
            end
        end
        if (do_pop) begin
            h = mq.pop_front();
            if (h.load) mt.push_back('{h.slot, int'(h.addr[1:0]), h.fn3});
        end
        if (do_push) begin
            r = '{g, slot_addr[g], slot_data[g], slot_fn3[g], slot_load[g]};
            mq.push_back(r);
            m_rr = (g + 1) % N;
        end
    endtask

    typedef struct {
        logic [N-1:0] req;
        logic         ack;
        logic [N-1:0] exp_full;
        logic         exp_mreq;
        logic [31:0]  exp_addr;
    } vec_t;
    vec_t tbl [21];

    logic [31:0] exp_lb, exp_lhu;
    logic [2:0]  fns [5];

    initial begin
        tbl[0]  = '{4'hF, 1'b1, 4'b1110, 1'b0, 32'h0};
        tbl[1]  = '{4'hF, 1'b1, 4'b1101, 1'b1, 32'h1000};
        tbl[2]  = '{4'hF, 1'b1, 4'b1011, 1'b1, 32'h1010};
        tbl[3]  = '{4'hF, 1'b1, 4'b0111, 1'b1, 32'h1020};
        tbl[4]  = '{4'hF, 1'b1, 4'b1110, 1'b1, 32'h1030};
        tbl[5]  = '{4'hF, 1'b1, 4'b1101, 1'b1, 32'h1000};
        tbl[6]  = '{4'h0, 1'b1, 4'b1111, 1'b1, 32'h1010};
        tbl[7]  = '{4'h0, 1'b0, 4'b1111, 1'b0, 32'h0};
        tbl[8]  = '{4'hF, 1'b0, 4'b1011, 1'b0, 32'h0};
        tbl[9]  = '{4'hF, 1'b0, 4'b0111, 1'b1, 32'h1020};
        tbl[10] = '{4'hF, 1'b0, 4'b1110, 1'b1, 32'h1020};
        tbl[11] = '{4'hF, 1'b0, 4'b1101, 1'b1, 32'h1020};
        tbl[12] = '{4'hF, 1'b0, 4'b1111, 1'b1, 32'h1020};
        tbl[13] = '{4'hF, 1'b1, 4'b1111, 1'b1, 32'h1020};
        tbl[14] = '{4'hF, 1'b0, 4'b1011, 1'b1, 32'h1030};
        tbl[15] = '{4'hF, 1'b0, 4'b1111, 1'b1, 32'h1030};
        tbl[16] = '{4'h0, 1'b1, 4'b1111, 1'b1, 32'h1030};
        tbl[17] = '{4'h0, 1'b1, 4'b1111, 1'b1, 32'h1000};
        tbl[18] = '{4'h0, 1'b1, 4'b1111, 1'b1, 32'h1010};
        tbl[19] = '{4'h0, 1'b1, 4'b1111, 1'b1, 32'h1020};
        tbl[20] = '{4'h0, 1'b1, 4'b1111, 1'b0, 32'h0};
`ifdef RCA_LSQ_LOAD_EXTRACT_EN
        exp_lb  = 32'hFFFFFF80;
        exp_lhu = 32'h000080FF;
`else
        exp_lb  = 32'h80FFFFFF;
        exp_lhu = 32'h80FFFFFF;
`endif
        fns = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        drive_idle();
        #2;
        do_reset();

        // Round-robin grants, backpressure and single-pop refill (all stores).
        for (int i = 0; i < 21; i++) begin
            for (int s = 0; s < N; s++) begin
                slot_addr[s] = 32'h1000 + 32'(16 * s);
                slot_data[s] = 32'hA0 + 32'(s);
            end
            slot_store       = 4'hF;
            slot_load        = 4'h0;
            slot_new_request = tbl[i].req;
            mem_ack          = tbl[i].ack;
            sample();
            check($sformatf("tbl%0d_full", i), slot_lsq_full, tbl[i].exp_full);
            check($sformatf("tbl%0d_mreq", i), mem_request, tbl[i].exp_mreq);
            check($sformatf("tbl%0d_addr", i), mem_addr, tbl[i].exp_addr);
            advance();
        end

        // Single load from slot 2, return two cycles after the ack.
        do_reset();
        mem_ack = 1'b1;
        put_req(2, 1'b1, 32'h104, 32'h0, 3'b010);
        sample(); check("ld_full", slot_lsq_full, 4'b1011);
        advance();
        slot_new_request = '0;
        sample(); check("ld_issue", {mem_request, mem_load, mem_addr, mem_fn3}, {1'b1, 1'b1, 32'h104, 3'b010});
        advance();
        sample(); check("ld_noreq", mem_request, 1'b0);
        advance();
        mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
        sample(); check("ld_cmpl_early", slot_load_complete, 4'h0);
        advance();
        mem_rvalid = 1'b0; mem_rdata = '0;
        sample();
        check("ld_cmpl", slot_load_complete, 4'b0100);
        check("ld_data", slot_load_data, {32'h0, 32'hDEADBEEF, 32'h0, 32'h0});
        advance();
        sample();
        check("ld_cmpl_once", slot_load_complete, 4'h0);
        check("ld_data_hold", slot_load_data[2], 32'hDEADBEEF);

        // Mixed load/store/load, in-order return, no store completion.
        advance();
        do_reset();
        mem_ack = 1'b1;
        put_req(1, 1'b1, 32'h200, 32'h0, 3'b010);
        sample(); check("mix_full0", slot_lsq_full, 4'b1101);
        advance();
        slot_new_request = '0;
        put_req(3, 1'b0, 32'h300, 32'h33, 3'b010);
        sample();
        check("mix_full1", slot_lsq_full, 4'b0111);
        check("mix_head0", {mem_request, mem_load, mem_addr}, {1'b1, 1'b1, 32'h200});
        advance();
        slot_new_request = '0;
        put_req(0, 1'b1, 32'h400, 32'h0, 3'b010);
        sample();
        check("mix_full2", slot_lsq_full, 4'b1110);
        check("mix_head1", {mem_request, mem_store, mem_addr, mem_wdata}, {1'b1, 1'b1, 32'h300, 32'h33});
        advance();
        slot_new_request = '0;
        sample(); check("mix_head2", {mem_request, mem_load, mem_addr}, {1'b1, 1'b1, 32'h400});
        advance();
        mem_rvalid = 1'b1; mem_rdata = 32'h11;
        advance();
        mem_rdata = 32'h22;
        sample();
        check("mix_cmpl1", slot_load_complete, 4'b0010);
        check("mix_data1", slot_load_data[1], 32'h11);
        advance();
        mem_rvalid = 1'b0;
        sample();
        check("mix_cmpl0", slot_load_complete, 4'b0001);
        check("mix_data", slot_load_data, {32'h0, 32'h0, 32'h11, 32'h22});
        advance();
        sample(); check("mix_none", slot_load_complete, 4'h0);

        // Byte / halfword extraction.
        advance();
        do_reset();
        mem_ack = 1'b1;
        put_req(0, 1'b1, 32'h3, 32'h0, 3'b000);
        advance();
        put_req(0, 1'b1, 32'h2, 32'h0, 3'b101);
        advance();
        slot_new_request = '0;
        mem_rvalid = 1'b1; mem_rdata = 32'h80FFFFFF;
        advance();
        sample();
        check("lb_cmpl", slot_load_complete, 4'b0001);
        check("lb_data", slot_load_data[0], exp_lb);
        advance();
        mem_rvalid = 1'b0;
        sample();
        check("lhu_cmpl", slot_load_complete, 4'b0001);
        check("lhu_data", slot_load_data[0], exp_lhu);

        // Empty-tracker return, then reset mid-queue.
        advance();
        do_reset();
        mem_rvalid = 1'b1;
        sample(); check("perr_pre", protocol_error, 1'b0);
        advance();
        mem_rvalid = 1'b0;
        sample(); check("perr_set", {protocol_error, slot_load_complete}, {1'b1, 4'h0});
        for (int s = 0; s < N; s++) put_req(s, 1'b1, 32'h500 + 32'(4 * s), 32'h0, 3'b010);
        advance();
        advance();
        sample(); check("perr_sticky", {protocol_error, mem_request}, 2'b11);
        #2 rst = 1'b0;
        #1 check_reset_outputs("midrst");
        advance();
        rst = 1'b1;
        slot_new_request = '0;
        sample();
        check("post_rst", {mem_request, protocol_error, slot_lsq_full, mem_addr}, {1'b0, 1'b0, 4'hF, 32'h0});
        // A load in flight across reset returns into an empty tracker.
        advance();
        mem_ack = 1'b1;
        put_req(0, 1'b1, 32'h600, 32'h0, 3'b010);
        advance();
        slot_new_request = '0;
        advance();
        rst = 1'b0;
        advance();
        rst = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'h77;
        advance();
        mem_rvalid = 1'b0;
        sample();
        check("stale_ret", {protocol_error, slot_load_complete, slot_load_data[0]}, {1'b1, 4'h0, 32'h0});

        // Randomized traffic against the reference model.
        advance();
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            for (int s = 0; s < N; s++) begin
                slot_new_request[s] = ($urandom_range(0, 2) != 0);
                slot_load[s]        = $urandom_range(0, 1) != 0;
                slot_store[s]       = !slot_load[s];
                slot_addr[s]        = $urandom;
                slot_data[s]        = $urandom;
                slot_fn3[s]         = fns[$urandom_range(0, 4)];
            end
            mem_ack    = ($urandom_range(0, 3) != 0);
            mem_rvalid = (mt.size() > 0) && ($urandom_range(0, 1) != 0);
            mem_rdata  = $urandom;
            sample();
            model_compare();
            @(posedge clk);
            model_update();
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
